// File: rtl/t07_spitft_pkg.sv
// -----------------------------------------------------------------------------
// t07_spitft_pkg
// Shared types and constants for the t07 SPI TFT arbiter/sequencer.
//   state_t          : sequencer states (IDLE, ISSUE, SHIFT, GAP, DONE)
//   READ_CMD         : frame command byte that marks a read transaction
//   GAP_*/FRAME_*    : bit positions of the gap and frame fields of a word
//   *_DEFAULT        : default values for the MIN_GAP and TIMEOUT parameters
//   is_read()        : true when a request word carries a read frame
// -----------------------------------------------------------------------------
package t07_spitft_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    localparam logic [7:0] READ_CMD = 8'h40;

    localparam int GAP_MSB   = 31;
    localparam int GAP_LSB   = 16;
    localparam int FRAME_MSB = 15;
    localparam int FRAME_LSB = 0;

    localparam int MIN_GAP_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT = 64;

    // The command byte is the upper half of the 16-bit SPI frame.
    function automatic logic is_read(input logic [31:0] w);
        return (w[FRAME_MSB:FRAME_LSB+8] == READ_CMD);
    endfunction

endpackage

// File: rtl/t07_spitft_arb_if.sv
// -----------------------------------------------------------------------------
// t07_spitft_arb_if
// Bundles the two requester ports, the SPI master link and the status flags
// of the t07 SPI TFT arbiter.
//   reqN_valid/word/lock : request from port N (word = {gap, frame})
//   reqN_ready/done      : one-cycle accept / completion pulses to port N
//   reqN_rdata           : read byte returned with reqN_done
//   spi_in/spi_wi        : word and transaction request to the SPI master
//   spi_ack/spi_miso     : busy indication and read byte from the SPI master
//   err/busy             : timeout abort pulse, sequencer-not-idle flag
// Modports: slave = arbiter side, master = requesters plus SPI master side.
// -----------------------------------------------------------------------------
interface t07_spitft_arb_if;

    logic        req0_valid;
    logic [31:0] req0_word;
    logic        req0_lock;
    logic        req0_ready;
    logic        req0_done;
    logic [7:0]  req0_rdata;

    logic        req1_valid;
    logic [31:0] req1_word;
    logic        req1_lock;
    logic        req1_ready;
    logic        req1_done;
    logic [7:0]  req1_rdata;

    logic [31:0] spi_in;
    logic        spi_wi;
    logic        spi_ack;
    logic [7:0]  spi_miso;

    logic        err;
    logic        busy;

    modport slave (
        input  req0_valid, req0_word, req0_lock,
        output req0_ready, req0_done, req0_rdata,
        input  req1_valid, req1_word, req1_lock,
        output req1_ready, req1_done, req1_rdata,
        output spi_in, spi_wi,
        input  spi_ack, spi_miso,
        output err, busy
    );

    modport master (
        output req0_valid, req0_word, req0_lock,
        input  req0_ready, req0_done, req0_rdata,
        output req1_valid, req1_word, req1_lock,
        input  req1_ready, req1_done, req1_rdata,
        input  spi_in, spi_wi,
        output spi_ack, spi_miso,
        input  err, busy
    );

endinterface

// File: rtl/t07_rr_arb2.sv
// -----------------------------------------------------------------------------
// t07_rr_arb2
// Two-way round-robin arbiter with lock hold.
//   clk, rst   : clock, synchronous active-high reset
//   valid[1:0] : request lines of port 1 / port 0
//   upd        : a transaction has finished; record its owner and lock
//   upd_port   : owner of the finished transaction
//   upd_lock   : keep the grant on upd_port for its next word
//   gnt        : a port may be granted this cycle
//   gnt_port   : which port is granted (valid with gnt)
// -----------------------------------------------------------------------------
module t07_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       upd,
    input  logic       upd_port,
    input  logic       upd_lock,
    output logic       gnt,
    output logic       gnt_port
);

    logic last_grant;
    logic lock_held;

    // last_grant resets to 1 so that port 0 wins the first contested grant.
    // While a lock is held the locked port is always last_grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            lock_held  <= 1'b0;
        end else if (upd) begin
            last_grant <= upd_port;
            lock_held  <= upd_lock;
        end
    end

    // A held lock only ever grants the locked port, so the other port waits
    // even when the locked one has nothing to send. Without a lock, a
    // contested cycle goes to the port that did not go last.
    always_comb begin
        gnt      = 1'b0;
        gnt_port = 1'b0;
        if (lock_held) begin
            gnt      = valid[last_grant];
            gnt_port = last_grant;
        end else begin
            case (valid)
                2'b01: begin
                    gnt      = 1'b1;
                    gnt_port = 1'b0;
                end
                2'b10: begin
                    gnt      = 1'b1;
                    gnt_port = 1'b1;
                end
                2'b11: begin
                    gnt      = 1'b1;
                    gnt_port = ~last_grant;
                end
                default: begin
                    gnt      = 1'b0;
                    gnt_port = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/t07_spitft_arb.sv
// -----------------------------------------------------------------------------
// t07_spitft_arb
// Shares the t07 SPI TFT master between the CPU memory handler (port 0) and
// the display init/fill sequencer (port 1). One request word is
// {gap[15:0], frame[15:0]}; the block grants round-robin (with burst lock),
// holds the word on spi_in, follows spi_ack to completion, waits
// MIN_GAP + gap idle cycles and returns the read byte with reqN_done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : t07_spitft_arb_if.slave (request ports, SPI link, err, busy)
// Parameters: MIN_GAP (idle cycles added to every gap), TIMEOUT (ISSUE wait).
// Optional build macro T07_SPIARB_TIMEOUT_EN: abort a transaction whose
// spi_ack never rises within TIMEOUT ISSUE cycles (err pulse, rdata 8'hFF).
// Without it err is tied 0 and ISSUE waits indefinitely.
// -----------------------------------------------------------------------------
module t07_spitft_arb
    import t07_spitft_pkg::*;
#(
    parameter int MIN_GAP = MIN_GAP_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    t07_spitft_arb_if.slave bus
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] word_q;
    logic        lock_q;
    logic        port_q;
    logic [16:0] gap_cnt;
    logic [7:0]  rbyte;
    logic [7:0]  rdata0_q;
    logic [7:0]  rdata1_q;
    logic [1:0]  ready_q;
    logic [1:0]  done_q;
    logic        gnt;
    logic        gnt_port;
    logic        abort;
    logic        arb_upd;
    logic        arb_upd_lock;

`ifdef T07_SPIARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
    logic            err_q;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    // The owner of a finished word becomes last_grant; its lock survives only
    // on a normal completion, an abort always releases it.
    assign arb_upd      = (state == DONE) || abort;
    assign arb_upd_lock = (state == DONE) && lock_q;

    t07_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid    ({bus.req1_valid, bus.req0_valid}),
        .upd      (arb_upd),
        .upd_port (port_q),
        .upd_lock (arb_upd_lock),
        .gnt      (gnt),
        .gnt_port (gnt_port)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. GAP leaves when the counter is about to expire so
    // that exactly MIN_GAP + gap cycles are spent there.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (bus.spi_ack) begin
                    state_nxt = SHIFT;
                end
`ifdef T07_SPIARB_TIMEOUT_EN
                else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            SHIFT: begin
                if (!bus.spi_ack) state_nxt = GAP;
            end
            GAP: begin
                if (gap_cnt <= 17'd1) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: latches the granted word, captures the read byte while the
    // master shifts, runs the gap counter and produces the ready/done pulses.
    // done is registered on the GAP->DONE edge so it is high in DONE with the
    // matching rdata already in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q   <= 32'h0;
            lock_q   <= 1'b0;
            port_q   <= 1'b0;
            gap_cnt  <= 17'h0;
            rbyte    <= 8'h00;
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
            ready_q  <= 2'b00;
            done_q   <= 2'b00;
`ifdef T07_SPIARB_TIMEOUT_EN
            to_cnt   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            ready_q <= 2'b00;
            done_q  <= 2'b00;
`ifdef T07_SPIARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (gnt) begin
                        word_q  <= gnt_port ? bus.req1_word : bus.req0_word;
                        lock_q  <= gnt_port ? bus.req1_lock : bus.req0_lock;
                        port_q  <= gnt_port;
                        ready_q <= gnt_port ? 2'b10 : 2'b01;
                        rbyte   <= 8'h00;
`ifdef T07_SPIARB_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end
                end
                ISSUE: begin
`ifdef T07_SPIARB_TIMEOUT_EN
                    if (abort) begin
                        done_q <= port_q ? 2'b10 : 2'b01;
                        err_q  <= 1'b1;
                        if (port_q) rdata1_q <= 8'hFF;
                        else        rdata0_q <= 8'hFF;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                SHIFT: begin
                    if (bus.spi_ack) begin
                        rbyte <= is_read(word_q) ? bus.spi_miso : 8'h00;
                    end else begin
                        gap_cnt <= 17'(MIN_GAP) + 17'(word_q[GAP_MSB:GAP_LSB]);
                    end
                end
                GAP: begin
                    if (gap_cnt <= 17'd1) begin
                        gap_cnt <= 17'h0;
                        done_q  <= port_q ? 2'b10 : 2'b01;
                        if (port_q) rdata1_q <= rbyte;
                        else        rdata0_q <= rbyte;
                    end else begin
                        gap_cnt <= gap_cnt - 17'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.spi_in     = word_q;
    assign bus.spi_wi     = (state == ISSUE) || (state == SHIFT);
    assign bus.busy       = (state != IDLE);
    assign bus.req0_ready = ready_q[0];
    assign bus.req1_ready = ready_q[1];
    assign bus.req0_done  = done_q[0];
    assign bus.req1_done  = done_q[1];
    assign bus.req0_rdata = rdata0_q;
    assign bus.req1_rdata = rdata1_q;

`ifdef T07_SPIARB_TIMEOUT_EN
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule
